// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter clocked by the toggling baud level (each edge = one bit tick).
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_baud,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy
);

  localparam int               CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_baud_q;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     w_bit_cnt_nx;
  logic                 r_stop_cnt;
  logic                 w_stop_cnt_nx;
  logic                 r_tx;
  logic                 w_tx_nx;
  logic                 r_tx_ready;
  logic                 r_tx_busy;
  logic                 w_tick;
  logic                 w_handshake;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
  logic                 w_parity_nx;
`endif

  assign w_tick      = i_baud ^ r_baud_q;
  assign w_handshake = i_tx_valid && r_tx_ready;

  // Next-state and next-output logic; a tick is ignored while IDLE, so a
  // tick coinciding with the handshake never shortens SYNC.
  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_stop_cnt_nx = r_stop_cnt;
    w_tx_nx       = r_tx;
`ifdef UART_TX_PARITY_EN
    w_parity_nx   = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (w_handshake) begin
          w_shift_nx    = i_tx_data;
          w_bit_cnt_nx  = '0;
          w_stop_cnt_nx = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_nx   = ^i_tx_data;
`endif
          w_state_nx    = S_SYNC;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SYNC: begin
        if (w_tick) begin
          w_tx_nx    = 1'b0;
          w_state_nx = S_START;
        end else begin
          w_state_nx = S_SYNC;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_tx_nx      = r_shift[0];
          w_shift_nx   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nx = CNT_W'(1);
          w_state_nx   = S_DATA;
        end else begin
          w_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (w_tick && (r_bit_cnt < LAST_BIT)) begin
          w_tx_nx      = r_shift[0];
          w_shift_nx   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nx = r_bit_cnt + CNT_W'(1);
        end else if (w_tick) begin
`ifdef UART_TX_PARITY_EN
          w_tx_nx       = r_parity;
          w_state_nx    = S_PARITY;
`else
          w_tx_nx       = 1'b1;
          w_stop_cnt_nx = 1'b0;
          w_state_nx    = S_STOP;
`endif
        end else begin
          w_state_nx = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_tx_nx       = 1'b1;
          w_stop_cnt_nx = 1'b0;
          w_state_nx    = S_STOP;
        end else begin
          w_state_nx = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        w_tx_nx = 1'b1;
        if (w_tick && (r_stop_cnt == STOP_LAST)) begin
          w_state_nx = S_IDLE;
        end else if (w_tick) begin
          w_stop_cnt_nx = r_stop_cnt + 1'b1;
        end else begin
          w_state_nx = S_STOP;
        end
      end
      default: begin
        w_tx_nx    = 1'b1;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; ready/busy track the next state
  // so they equal "state is IDLE" without a combinational output path.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_baud_q   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_baud_q   <= i_baud;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_stop_cnt <= w_stop_cnt_nx;
      r_tx       <= w_tx_nx;
      r_tx_ready <= (w_state_nx == S_IDLE);
      r_tx_busy  <= (w_state_nx != S_IDLE);
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_nx;
`endif
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_ready = r_tx_ready;
  assign o_tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: decodes the serial line like a receiver and compares frames with
// hand-written vectors and an arithmetic frame model; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BAUD_DIV  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int NB = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       baud     = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       baud_en  = 1'b1;
  int         baud_div_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
  } vec_t;
  vec_t vecs[11];

  uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_baud     (baud),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_tx       (tx),
    .o_tx_busy  (tx_busy)
  );

  initial forever #5 clk = ~clk;

  // baud level toggles every BAUD_DIV clocks while enabled
  initial forever begin
    @(negedge clk);
    if (baud_en) begin
      baud_div_cnt++;
      if (baud_div_cnt == BAUD_DIV) begin
        baud_div_cnt = 0;
        baud = ~baud;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame bits in line order: bit 0 = start, then data LSB first, parity, stops.
  function automatic logic [11:0] model_frame(input logic [7:0] d);
    logic [11:0] f;
    int pos;
    f = 12'h000;
    for (int i = 0; i < DATA_BITS; i++) f[1 + i] = d[i];
    pos = 1 + DATA_BITS;
    if (PAR_BITS == 1) begin
      f[pos] = ($countones(d) % 2) == 1;
      pos++;
    end
    for (int s = 0; s < STOP_BITS; s++) f[pos + s] = 1'b1;
    return f;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // one handshake; optionally scrambles tx_data while the frame is in flight
  task automatic send(input logic [7:0] d, input bit scramble);
    int waited;
    waited = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      fail_bound("handshake");
      tx_valid = 1'b0;
      return;
    end
    sample();
    check1("busy_after_hs", {tx_busy, tx_ready}, 2'b10);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = scramble ? 8'($urandom) : d;
  endtask

  // two bytes with tx_valid held high across both handshakes
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    tx_data  = a;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    sample();
    @(negedge clk);
    tx_data = b;
    waited  = 0;
    while (tx_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) fail_bound("handshake_pair");
    sample();
    check1("ready_one_cycle", {tx_busy, tx_ready}, 2'b10);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // receives one frame; lead = idle samples seen before the start bit.
  // Ends with one sample past the last stop bit.
  task automatic rx_frame(output logic [11:0] frame, output int lead, output bit started);
    bit hold_ok;
    bit busy_ok;
    frame   = 12'h000;
    lead    = 0;
    started = 1'b0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    sample();
    while (tx !== 1'b0 && lead < 300) begin
      lead++;
      sample();
    end
    if (tx !== 1'b0) begin
      fail_bound("rx_start");
      return;
    end
    started = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int s = 0; s < BAUD_DIV; s++) begin
        if (b != 0 || s != 0) sample();
        if (s == 0) frame[b] = tx;
        else if (tx !== frame[b]) hold_ok = 1'b0;
        if (tx_busy !== 1'b1 || tx_ready !== 1'b0) busy_ok = 1'b0;
      end
    end
    check1("bit_hold", 32'(hold_ok), 32'd1);
    check1("busy_in_frame", 32'(busy_ok), 32'd1);
    sample();
    check1("ready_after_stop", {tx_ready, tx}, 2'b11);
  endtask

  initial begin
    logic [11:0] f1;
    logic [11:0] f2;
    int          l1;
    int          l2;
    bit          st1;
    bit          st2;
    logic [7:0]  d;
    bit          quiet_ok;

`ifdef UART_TX_PARITY_EN
    vecs = '{
      '{8'h55, {1'b0, 1'b1, 1'b0, 8'h55, 1'b0}}, '{8'hA3, {1'b0, 1'b1, 1'b0, 8'hA3, 1'b0}},
      '{8'h0F, {1'b0, 1'b1, 1'b0, 8'h0F, 1'b0}}, '{8'h81, {1'b0, 1'b1, 1'b0, 8'h81, 1'b0}},
      '{8'h3C, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}}, '{8'h00, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}},
      '{8'hFF, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}}, '{8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}},
      '{8'h03, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}}, '{8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}},
      '{8'h80, {1'b0, 1'b1, 1'b1, 8'h80, 1'b0}}};
`else
    vecs = '{
      '{8'h55, {2'b00, 1'b1, 8'h55, 1'b0}}, '{8'hA3, {2'b00, 1'b1, 8'hA3, 1'b0}},
      '{8'h0F, {2'b00, 1'b1, 8'h0F, 1'b0}}, '{8'h81, {2'b00, 1'b1, 8'h81, 1'b0}},
      '{8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}}, '{8'h00, {2'b00, 1'b1, 8'h00, 1'b0}},
      '{8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}}, '{8'h07, {2'b00, 1'b1, 8'h07, 1'b0}},
      '{8'h03, {2'b00, 1'b1, 8'h03, 1'b0}}, '{8'h01, {2'b00, 1'b1, 8'h01, 1'b0}},
      '{8'h80, {2'b00, 1'b1, 8'h80, 1'b0}}};
`endif

    repeat (3) sample();
    check1("reset_values", {tx, tx_ready, tx_busy}, 3'b110);
    @(negedge clk);
    reset = 1'b0;

    // idle with baud running: line and handshake outputs stay put
    for (int i = 0; i < 40; i++) begin
      sample();
      check1("idle_quiet", {tx, tx_ready, tx_busy}, 3'b110);
    end

    // hand-written vectors
    for (int v = 0; v < 11; v++) begin
      fork
        send(vecs[v].data, 1'b1);
        rx_frame(f1, l1, st1);
      join
      if (st1) check1("vec_frame", 32'(f1), 32'(vecs[v].frame));
      if (st1) check1("vec_sync_latency", 32'((l1 >= 1) && (l1 <= BAUD_DIV)), 32'd1);
    end

    // back-to-back frames, tx_valid held high
    fork
      send_pair(8'hA3, 8'h0F);
      begin
        rx_frame(f1, l1, st1);
        rx_frame(f2, l2, st2);
      end
    join
    if (st1) check1("b2b_first", 32'(f1), 32'(model_frame(8'hA3)));
    if (st2) check1("b2b_second", 32'(f2), 32'(model_frame(8'h0F)));
    // one post-stop idle sample is consumed by the first receive
    if (st2) check1("b2b_gap", 32'(l2), 32'(BAUD_DIV - 1));

    // tx_valid pulse while busy must not create a handshake
    fork
      send(8'h81, 1'b0);
      rx_frame(f1, l1, st1);
      begin
        repeat (22) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    if (st1) check1("busy_valid_ignored", 32'(f1), 32'(model_frame(8'h81)));
    quiet_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sample();
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet_ok = 1'b0;
    end
    check1("no_extra_frame", 32'(quiet_ok), 32'd1);

    // reset pulse during the 4th data bit
    fork
      send(8'hA5, 1'b0);
      begin
        l1 = 0;
        sample();
        while (tx !== 1'b0 && l1 < 300) begin
          l1++;
          sample();
        end
        if (tx !== 1'b0) fail_bound("reset_test_start");
        repeat (4 * BAUD_DIV + 1) sample();
        @(negedge clk);
        reset = 1'b1;
        sample();
        check1("midframe_reset", {tx, tx_ready, tx_busy}, 3'b110);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    fork
      send(8'h3C, 1'b1);
      rx_frame(f1, l1, st1);
    join
    if (st1) check1("after_reset_frame", 32'(f1), 32'(model_frame(8'h3C)));

    // baud stuck: frame waits in SYNC indefinitely, then resumes cleanly
    baud_en = 1'b0;
    send(8'hC6, 1'b1);
    quiet_ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sample();
      if (tx !== 1'b1 || tx_busy !== 1'b1 || tx_ready !== 1'b0) quiet_ok = 1'b0;
    end
    check1("baud_stuck_hold", 32'(quiet_ok), 32'd1);
    baud_en = 1'b1;
    rx_frame(f1, l1, st1);
    if (st1) check1("baud_resume_frame", 32'(f1), 32'(model_frame(8'hC6)));

    // randomized bytes and spacing against the frame model
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      fork
        send(d, 1'b1);
        rx_frame(f1, l1, st1);
      join
      if (st1) check1("rand_frame", 32'(f1), 32'(model_frame(d)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
